// File: rtl/transducer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : transducer_pkg                                               |
// | Description : Shared types and constants for the transducer fire           |
// |               sequencer: FSM state encoding, default counter/datapath      |
// |               widths and the minimum arm duration.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package transducer_pkg;

  // Sequencer states; explicit 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    FIRE      = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4,
    INTERVAL  = 3'd5
  } state_e;

  // Default widths: small counters, pulse datapath, interval datapath.
  localparam int CT_W = 9;
  localparam int PD_W = 16;
  localparam int FD_W = 32;

  // Channels need at least two mark-only cycles to enter MARK and latch delays.
  localparam int ARM_CYCLES_MIN = 2;

endpackage : transducer_pkg
`default_nettype wire

// File: rtl/transducer_fire_sequencer_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_down_counter                                             |
// | Description : Loadable down counter with zero flag. Load has priority      |
// |               over decrement; decrement stops at zero.                     |
// | Ports       : clk, rst_n       - clock, async active-low reset             |
// |               i_load/i_load_val - load request and value                   |
// |               i_dec            - decrement request                         |
// |               o_zero           - count is zero                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_down_counter
  import transducer_pkg::*;
#(
  parameter int WIDTH = CT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule : seq_down_counter
`default_nettype wire

// File: rtl/transducer_fire_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : transducer_fire_sequencer                                    |
// | Description : Runs a programmed burst of fire events across NCH channels:  |
// |               arm -> fire -> wait-for-complete -> release, with a          |
// |               programmed interval between events. All outputs registered.  |
// | Ports       : clk, rst_n           - clock, async active-low reset         |
// |               i_start, i_abort     - burst request / abort level           |
// |               i_cfg_*              - mask, pulse count, interval (latched) |
// |               i_fire_complete      - per-channel fireComplete              |
// |               o_chan_active        - isActive mask (0 in IDLE)             |
// |               o_on_your_mark/o_gogogo/o_chan_rst - channel handshake       |
// |               o_busy, o_burst_done, o_timeout_err, o_pulse_count - status  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module transducer_fire_sequencer
  import transducer_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int ARM_CYCLES = 2,
  parameter int TIMEOUT    = 65535,
  parameter int CNT_W      = PD_W,
  parameter int IVL_W      = FD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [NCH-1:0]   i_cfg_chan_en,
  input  logic [CNT_W-1:0] i_cfg_num_pulses,
  input  logic [IVL_W-1:0] i_cfg_interval,
  input  logic [NCH-1:0]   i_fire_complete,
  output logic [NCH-1:0]   o_chan_active,
  output logic             o_on_your_mark,
  output logic             o_gogogo,
  output logic             o_chan_rst,
  output logic             o_busy,
  output logic             o_burst_done,
  output logic             o_timeout_err,
  output logic [CNT_W-1:0] o_pulse_count
);

  localparam int ARM_LOAD = (ARM_CYCLES < ARM_CYCLES_MIN) ? ARM_CYCLES_MIN : ARM_CYCLES;
  localparam int TO_LOAD  = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int TO_W     = (TO_LOAD < 2) ? 1 : $clog2(TO_LOAD);

  state_e r_state, w_next;

  logic [NCH-1:0]   r_mask;
  logic [CNT_W-1:0] r_num;
  logic [IVL_W-1:0] r_interval;
  logic [CNT_W-1:0] r_pulse_count;
  logic             r_timeout_err;
  logic             r_aborting;    // current RELEASE ends the burst early
  logic             r_rel_counts;  // current RELEASE follows an issued GO

  logic [NCH-1:0]   r_chan_active;
  logic             r_mark, r_go, r_chan_rst, r_busy, r_burst_done;

  logic             w_arm_zero, w_to_zero, w_ivl_zero;
  logic             w_accept, w_all_done, w_last;
  logic [CNT_W-1:0] w_pc_inc;
  logic             w_to_rel_abort, w_timeout, w_burst_end;
  logic             w_mark_d, w_go_d, w_chan_rst_d;
  logic [NCH-1:0]   w_mask_nxt;

  assign w_accept   = (r_state == IDLE) && i_start;
  assign w_all_done = &(i_fire_complete | ~r_mask);
  assign w_pc_inc   = (r_pulse_count == '1) ? r_pulse_count : r_pulse_count + CNT_W'(1);
  assign w_last     = (w_pc_inc == r_num);
  assign w_mask_nxt = w_accept ? i_cfg_chan_en : r_mask;

  // Counters are loaded one below the wanted duration so "zero" marks the last cycle.
  seq_down_counter #(.WIDTH(CT_W)) u_arm_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     ((w_next == ARM) && (r_state != ARM)),
    .i_load_val (CT_W'(ARM_LOAD - 1)),
    .i_dec      (r_state == ARM),
    .o_zero     (w_arm_zero)
  );

  seq_down_counter #(.WIDTH(TO_W)) u_timeout_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (r_state == FIRE),
    .i_load_val (TO_W'(TO_LOAD - 1)),
    .i_dec      (r_state == WAIT_DONE),
    .o_zero     (w_to_zero)
  );

  seq_down_counter #(.WIDTH(IVL_W)) u_interval_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     ((r_state == RELEASE) && (w_next == INTERVAL)),
    .i_load_val (r_interval - IVL_W'(1)),
    .i_dec      (r_state == INTERVAL),
    .o_zero     (w_ivl_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort takes precedence over every other exit.
  always_comb begin
    w_next         = r_state;
    w_to_rel_abort = 1'b0;
    w_timeout      = 1'b0;
    w_burst_end    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_next = ARM;
      end
      ARM: begin
        if (i_abort) begin
          w_next = RELEASE; w_to_rel_abort = 1'b1;
        end else if (w_arm_zero) begin
          w_next = FIRE;
        end
      end
      FIRE: begin
        if (i_abort) begin
          w_next = RELEASE; w_to_rel_abort = 1'b1;
        end else begin
          w_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_abort) begin
          w_next = RELEASE; w_to_rel_abort = 1'b1;
        end else if (w_all_done) begin
          w_next = RELEASE;
        end else if (w_to_zero) begin
          w_next = RELEASE; w_to_rel_abort = 1'b1; w_timeout = 1'b1;
        end
      end
      RELEASE: begin
        if (r_aborting || i_abort) begin
          w_next = IDLE;
        end else if (w_last) begin
          w_next = IDLE; w_burst_end = 1'b1;
        end else if (r_interval == '0) begin
          w_next = ARM;
        end else begin
          w_next = INTERVAL;
        end
      end
      INTERVAL: begin
        if (i_abort) begin
          w_next = RELEASE; w_to_rel_abort = 1'b1;
        end else if (w_ivl_zero) begin
          w_next = ARM;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so registered outputs line up with it.
  always_comb begin
    w_mark_d     = 1'b0;
    w_go_d       = 1'b0;
    w_chan_rst_d = 1'b1;
    case (w_next)
      ARM:       begin w_mark_d = 1'b1; w_chan_rst_d = 1'b0; end
      FIRE:      begin w_mark_d = 1'b1; w_go_d = 1'b1; w_chan_rst_d = 1'b0; end
      WAIT_DONE: begin w_mark_d = 1'b1; w_go_d = 1'b1; w_chan_rst_d = 1'b0; end
      default:   begin w_mark_d = 1'b0; w_go_d = 1'b0; w_chan_rst_d = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan_active <= '0;
      r_mark        <= 1'b0;
      r_go          <= 1'b0;
      r_chan_rst    <= 1'b1;
      r_busy        <= 1'b0;
      r_burst_done  <= 1'b0;
    end else begin
      r_chan_active <= (w_next == IDLE) ? '0 : w_mask_nxt;
      r_mark        <= w_mark_d;
      r_go          <= w_go_d;
      r_chan_rst    <= w_chan_rst_d;
      r_busy        <= (w_next != IDLE);
      r_burst_done  <= w_burst_end;
    end
  end

  // Burst configuration and status. A RELEASE reached by abort from ARM or
  // INTERVAL never issued GO, so it does not count as a released pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask        <= '0;
      r_num         <= '0;
      r_interval    <= '0;
      r_pulse_count <= '0;
      r_timeout_err <= 1'b0;
      r_aborting    <= 1'b0;
      r_rel_counts  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mask        <= i_cfg_chan_en;
        r_num         <= (i_cfg_num_pulses == '0) ? CNT_W'(1) : i_cfg_num_pulses;
        r_interval    <= i_cfg_interval;
        r_pulse_count <= '0;
        r_timeout_err <= 1'b0;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
      if ((w_next == RELEASE) && (r_state != RELEASE)) begin
        r_aborting   <= w_to_rel_abort;
        r_rel_counts <= (r_state == FIRE) || (r_state == WAIT_DONE);
      end
      if ((r_state == RELEASE) && r_rel_counts) r_pulse_count <= w_pc_inc;
    end
  end

  assign o_chan_active  = r_chan_active;
  assign o_on_your_mark = r_mark;
  assign o_gogogo       = r_go;
  assign o_chan_rst     = r_chan_rst;
  assign o_busy         = r_busy;
  assign o_burst_done   = r_burst_done;
  assign o_timeout_err  = r_timeout_err;
  assign o_pulse_count  = r_pulse_count;

endmodule : transducer_fire_sequencer
`default_nettype wire

// File: tb/tb_transducer_fire_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_transducer_fire_sequencer                                 |
// | Description : Directed self-checking bench for transducer_fire_sequencer.  |
// |               Inputs change 1 time unit after each rising edge, outputs    |
// |               are sampled at the same point.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_transducer_fire_sequencer;

  logic        clk;
  logic        rst_n;
  logic        i_start, i_abort;
  logic [7:0]  i_cfg_chan_en;
  logic [15:0] i_cfg_num_pulses;
  logic [31:0] i_cfg_interval;
  logic [7:0]  i_fire_complete;
  logic [7:0]  o_chan_active;
  logic        o_on_your_mark, o_gogogo, o_chan_rst, o_busy, o_burst_done, o_timeout_err;
  logic [15:0] o_pulse_count;

  int errors = 0;
  int checks = 0;

  transducer_fire_sequencer #(
    .NCH(8), .ARM_CYCLES(2), .TIMEOUT(20), .CNT_W(16), .IVL_W(32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_cfg_chan_en    (i_cfg_chan_en),
    .i_cfg_num_pulses (i_cfg_num_pulses),
    .i_cfg_interval   (i_cfg_interval),
    .i_fire_complete  (i_fire_complete),
    .o_chan_active    (o_chan_active),
    .o_on_your_mark   (o_on_your_mark),
    .o_gogogo         (o_gogogo),
    .o_chan_rst       (o_chan_rst),
    .o_busy           (o_busy),
    .o_burst_done     (o_burst_done),
    .o_timeout_err    (o_timeout_err),
    .o_pulse_count    (o_pulse_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [7:0] m, input logic [15:0] n, input logic [31:0] iv,
                     input logic [7:0] fc);
    i_cfg_chan_en    = m;
    i_cfg_num_pulses = n;
    i_cfg_interval   = iv;
    i_fire_complete  = fc;
  endtask

  int   go_rises, rst_cycles, done_cnt, done_at;
  logic prev_go;

  initial begin
    rst_n = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    cfg(8'h00, 16'd0, 32'd0, 8'h00);
    #1 rst_n = 1'b0;
    #2;
    // ---------------- reset values (before any clock edge)
    chk("rst_chan_active", o_chan_active, 8'h00);
    chk("rst_mark", o_on_your_mark, 1'b0);
    chk("rst_go", o_gogogo, 1'b0);
    chk("rst_chan_rst", o_chan_rst, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_burst_done, 1'b0);
    chk("rst_terr", o_timeout_err, 1'b0);
    chk("rst_pcount", o_pulse_count, 16'd0);
    #19 rst_n = 1'b1;
    tick();

    // ---------------- single pulse, completion 5 cycles after GO
    cfg(8'h0F, 16'd1, 32'd0, 8'h00);
    i_start = 1'b1;
    tick();                       // E1: ARM
    i_start = 1'b0;
    chk("t1_arm1_mark", o_on_your_mark, 1'b1);
    chk("t1_arm1_go", o_gogogo, 1'b0);
    chk("t1_arm1_crst", o_chan_rst, 1'b0);
    chk("t1_arm1_busy", o_busy, 1'b1);
    chk("t1_arm1_active", o_chan_active, 8'h0F);
    tick();                       // E2: ARM
    chk("t1_arm2_mark", o_on_your_mark, 1'b1);
    chk("t1_arm2_go", o_gogogo, 1'b0);
    tick();                       // E3: FIRE
    chk("t1_fire_go", o_gogogo, 1'b1);
    chk("t1_fire_mark", o_on_your_mark, 1'b1);
    step(5);                      // E8: last WAIT_DONE cycle
    chk("t1_wait_go", o_gogogo, 1'b1);
    i_fire_complete = 8'h0F;
    tick();                       // E9: RELEASE
    chk("t1_rel_mark", o_on_your_mark, 1'b0);
    chk("t1_rel_go", o_gogogo, 1'b0);
    chk("t1_rel_crst", o_chan_rst, 1'b1);
    chk("t1_rel_busy", o_busy, 1'b1);
    chk("t1_rel_done", o_burst_done, 1'b0);
    tick();                       // E10: IDLE
    chk("t1_done", o_burst_done, 1'b1);
    chk("t1_pcount", o_pulse_count, 16'd1);
    chk("t1_idle_busy", o_busy, 1'b0);
    chk("t1_idle_active", o_chan_active, 8'h00);
    i_fire_complete = 8'h00;
    tick();
    chk("t1_done_pulse", o_burst_done, 1'b0);

    // ---------------- burst of 3 with interval 4
    cfg(8'hFF, 16'd3, 32'd4, 8'hFF);
    go_rises = 0; rst_cycles = 0; done_cnt = 0; done_at = 0; prev_go = 1'b0;
    i_start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      i_start = 1'b0;
      if (o_gogogo && !prev_go) go_rises++;
      prev_go = o_gogogo;
      if (o_busy && o_chan_rst) rst_cycles++;
      if (o_burst_done) begin
        done_cnt++;
        done_at = c;
      end
    end
    chk("t2_go_rises", go_rises, 3);
    chk("t2_rel_int_cycles", rst_cycles, 11);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_done_at", done_at, 24);
    chk("t2_pcount", o_pulse_count, 16'd3);
    i_fire_complete = 8'h00;

    // ---------------- timeout: channel 2 never completes
    cfg(8'h0F, 16'd1, 32'd0, 8'h0B);
    i_start = 1'b1;
    tick();                       // E1
    i_start = 1'b0;
    step(22);                     // E23: 20th WAIT_DONE cycle
    chk("t3_wait_go", o_gogogo, 1'b1);
    chk("t3_wait_terr", o_timeout_err, 1'b0);
    tick();                       // E24: RELEASE
    chk("t3_rel_terr", o_timeout_err, 1'b1);
    chk("t3_rel_go", o_gogogo, 1'b0);
    chk("t3_rel_crst", o_chan_rst, 1'b1);
    chk("t3_rel_busy", o_busy, 1'b1);
    tick();                       // E25: IDLE
    chk("t3_idle_busy", o_busy, 1'b0);
    chk("t3_no_done", o_burst_done, 1'b0);
    chk("t3_sticky", o_timeout_err, 1'b1);
    chk("t3_pcount", o_pulse_count, 16'd1);

    // ---------------- pulses=0 runs once; start while busy ignored
    cfg(8'h0F, 16'd0, 32'd0, 8'h0F);
    i_start = 1'b1;
    tick();                       // E1: ARM, start held high into ARM
    chk("t6_terr_clear", o_timeout_err, 1'b0);
    chk("t6_arm_busy", o_busy, 1'b1);
    tick();                       // E2
    i_start = 1'b0;
    step(3);                      // E5: RELEASE
    chk("t6_rel_go", o_gogogo, 1'b0);
    tick();                       // E6: IDLE
    chk("t6_done", o_burst_done, 1'b1);
    chk("t6_pcount", o_pulse_count, 16'd1);
    chk("t6_idle", o_busy, 1'b0);
    tick();
    chk("t6_no_restart", o_busy, 1'b0);

    // ---------------- abort mid-INTERVAL of a 5-pulse burst
    cfg(8'hFF, 16'd5, 32'd4, 8'hFF);
    i_start = 1'b1;
    tick();                       // E1
    i_start = 1'b0;
    step(14);                     // E15: second INTERVAL
    chk("t4_int_crst", o_chan_rst, 1'b1);
    chk("t4_int_busy", o_busy, 1'b1);
    chk("t4_int_pcount", o_pulse_count, 16'd2);
    i_abort = 1'b1;
    tick();                       // E16: RELEASE
    i_abort = 1'b0;
    chk("t4_rel_crst", o_chan_rst, 1'b1);
    chk("t4_rel_mark", o_on_your_mark, 1'b0);
    chk("t4_rel_busy", o_busy, 1'b1);
    tick();                       // E17: IDLE
    chk("t4_idle_busy", o_busy, 1'b0);
    chk("t4_no_done", o_burst_done, 1'b0);
    chk("t4_pcount", o_pulse_count, 16'd2);
    tick();
    chk("t4_stay_idle", o_busy, 1'b0);
    i_fire_complete = 8'h00;

    // ---------------- start and abort together: start wins, abort seen in ARM
    cfg(8'h0F, 16'd1, 32'd0, 8'h00);
    i_start = 1'b1; i_abort = 1'b1;
    tick();                       // E1: ARM
    i_start = 1'b0;
    chk("t7_arm_mark", o_on_your_mark, 1'b1);
    chk("t7_arm_busy", o_busy, 1'b1);
    tick();                       // E2: RELEASE
    i_abort = 1'b0;
    chk("t7_rel_mark", o_on_your_mark, 1'b0);
    chk("t7_rel_crst", o_chan_rst, 1'b1);
    tick();                       // E3: IDLE
    chk("t7_idle_busy", o_busy, 1'b0);
    chk("t7_no_done", o_burst_done, 1'b0);
    chk("t7_pcount", o_pulse_count, 16'd0);

    // ---------------- all-zero mask: WAIT_DONE lasts one cycle
    cfg(8'h00, 16'd1, 32'd0, 8'h00);
    i_start = 1'b1;
    tick();                       // E1
    i_start = 1'b0;
    chk("t8_arm_active", o_chan_active, 8'h00);
    step(3);                      // E4: WAIT_DONE
    chk("t8_wait_go", o_gogogo, 1'b1);
    tick();                       // E5: RELEASE
    chk("t8_rel_go", o_gogogo, 1'b0);
    chk("t8_rel_busy", o_busy, 1'b1);
    tick();                       // E6: IDLE
    chk("t8_done", o_burst_done, 1'b1);
    chk("t8_pcount", o_pulse_count, 16'd1);

    // ---------------- async reset while in WAIT_DONE
    cfg(8'hFF, 16'd1, 32'd0, 8'h00);
    i_start = 1'b1;
    tick();                       // E1
    i_start = 1'b0;
    step(3);                      // E4: WAIT_DONE
    chk("t5_wait_go", o_gogogo, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_crst", o_chan_rst, 1'b1);
    chk("t5_async_go", o_gogogo, 1'b0);
    chk("t5_async_mark", o_on_your_mark, 1'b0);
    chk("t5_async_busy", o_busy, 1'b0);
    chk("t5_async_active", o_chan_active, 8'h00);
    chk("t5_async_pcount", o_pulse_count, 16'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("t5_after_busy", o_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_transducer_fire_sequencer
`default_nettype wire

// File: doc/transducer_fire_sequencer.md
Name: transducer_fire_sequencer

Overview:
- Sequences a bank of NCH transducer output channels through a programmed burst of fire events.
- Each event runs arm -> fire -> wait-for-complete -> release. Between events the block waits a programmed interval.
- Drives the shared channel handshake lines: isActive mask, onYourMark, GOGOGO_EXCLAMATION, and a channel sync reset.
- Aggregates per-channel fireComplete. Sits between the host register block and the channel array.

Parameters:
NCH, 8, number of transducer channels driven
ARM_CYCLES, 2, cycles onYourMark is held alone before GO (must be >=2 so channels enter MARK and latch delays)
TIMEOUT, 65535, max cycles in WAIT_DONE before error abort
CNT_W, 16, width of pulse count
IVL_W, 32, width of inter-pulse interval

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a burst; honoured only in IDLE
abort  in  1  level; terminates burst at next state boundary
cfg_chan_en  in  NCH  channel enable mask, latched on accepted start
cfg_num_pulses  in  CNT_W  pulses per burst, latched on start; 0 treated as 1
cfg_interval  in  IVL_W  idle cycles between release and next arm, latched on start
fire_complete  in  NCH  per-channel fireComplete
chan_active  out  NCH  isActive per channel (latched mask, 0 in IDLE)
on_your_mark  out  1  broadcast mark
gogogo  out  1  broadcast go
chan_rst  out  1  active-high sync reset to channels
busy  out  1  high in any state but IDLE
burst_done  out  1  one-cycle pulse on normal burst completion
timeout_err  out  1  sticky; cleared on next accepted start
pulse_count  out  CNT_W  pulses released so far in current burst

Behaviour:
- Reset values (async on rst=0): state IDLE, chan_active=0, on_your_mark=0, gogogo=0, chan_rst=1, busy=0, burst_done=0, timeout_err=0, pulse_count=0. All counters are 0.
- All outputs are registered.
- IDLE: chan_rst=1, mark=0, go=0.
  - On start: latch cfg, clear pulse_count and timeout_err, load arm counter, go to ARM.
  - Start in any other state is ignored.
- ARM: chan_rst=0, chan_active=mask, mark=1, go=0. Lasts exactly ARM_CYCLES cycles, then FIRE.
- FIRE: mark=1, go=1, lasts 1 cycle; load timeout counter; go to WAIT_DONE. fire_complete is not sampled in FIRE.
- WAIT_DONE: mark=1, go=1.
  - Exit condition: (fire_complete | ~mask) all ones, evaluated from the 1st WAIT_DONE cycle. When met, go to RELEASE.
  - Else decrement the timeout counter. On reaching 0: set timeout_err and go to RELEASE with abort semantics.
- RELEASE: 1 cycle; mark=0, go=0, chan_rst=1; pulse_count+1.
  - Aborting (abort high or timeout): go to IDLE, no burst_done.
  - Else if pulse_count+1 == num_pulses: burst_done=1, go to IDLE.
  - Else if interval==0: go to ARM.
  - Else go to INTERVAL.
- INTERVAL: chan_rst=1, mark=0, go=0. Counts cfg_interval cycles down to 1, then ARM.
- abort:
  - Sampled in ARM, FIRE, WAIT_DONE and INTERVAL; each forces RELEASE next cycle.
  - In IDLE it is ignored. In RELEASE it marks the release as aborting.
  - Abort simultaneous with start in IDLE: start wins, and abort is then seen in ARM.
- Mask of all zeros: WAIT_DONE exits after 1 cycle; the burst still counts pulses.
- pulse_count saturates at max; it holds its value in IDLE until the next start.
- Timing of one pulse, start to release: 1 + ARM_CYCLES + 1 + N_wait + 1 cycles.

Decomposition:
- Package transducer_pkg holds:
  - state enum: IDLE, ARM, FIRE, WAIT_DONE, RELEASE, INTERVAL;
  - default widths CT_W=9, PD_W=16, FD_W=32;
  - the ARM_CYCLES minimum constant.
- One sub-module is natural: seq_down_counter (load/decrement/zero flag, parameterised width). It is instantiated for the arm, timeout and interval counters.

Test Plan:
- Single pulse: mask=8'h0F, pulses=1, interval=0, channels complete 5 cycles after go -> mark high 2 cycles before go; RELEASE 1 cycle; burst_done pulse at cycle 10 after start; pulse_count=1.
- Burst: pulses=3, interval=4 -> exactly 3 go assertions; each RELEASE is followed by 4 INTERVAL cycles with chan_rst=1; burst_done once; pulse_count=3.
- Timeout: TIMEOUT=20, channel 2 never completes -> timeout_err set after 20 WAIT_DONE cycles; RELEASE then IDLE; no burst_done; next start clears timeout_err.
- Abort mid-INTERVAL of a pulses=5 burst -> RELEASE next cycle, then IDLE; pulse_count holds 2; no burst_done.
- Async reset asserted in WAIT_DONE -> all outputs go to reset values immediately (chan_rst=1, go=0, busy=0) without waiting for clk.
- Start while busy, and pulses=0 -> the mid-burst start is ignored; pulses=0 runs exactly one pulse.
